// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional accumulate mode (port in_acc) is enabled by defining BOOTH_MUL_ACC_EN.
module booth_mul_seq #(
  parameter int W  = 16,
  parameter int CW = $clog2(W/2+2)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           in_signed,
`ifdef BOOTH_MUL_ACC_EN
  input  logic           in_acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
);

  localparam int XW = W + 2;
  localparam int AW = 2*W + 2;
  localparam logic [CW-1:0] FIN = CW'(W/2 + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  x_sh;
  logic [XW-1:0]  y_sh;
  logic           y_prev;
  logic [AW-1:0]  acc;

  logic [2:0]     bits;
  logic           neg, dbl, zero;
  logic [AW-1:0]  mult, pp, acc_nxt;
  logic [AW-1:0]  x_ext, acc_base;
  logic [XW-1:0]  y_ext;
  logic           x_sx, y_sx, do_acc;

  // Multiplicand shifts left and multiplier right, so the current digit
  // always sits in y_sh[1:0] with y_prev as the overlap bit.
  always_comb begin
    bits = {y_sh[1], y_sh[0], y_prev};
    neg  = 1'b0;
    dbl  = 1'b0;
    zero = 1'b0;
    case (bits)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         dbl  = 1'b1;
      3'b100:         begin neg = 1'b1; dbl = 1'b1; end
      default:        neg  = 1'b1;
    endcase
    mult    = dbl ? (x_sh << 1) : x_sh;
    pp      = zero ? '0 : (neg ? ~mult : mult);
    acc_nxt = acc + pp + AW'(neg & ~zero);
  end

  always_comb begin
    x_sx  = in_signed & in_x[W-1];
    y_sx  = in_signed & in_y[W-1];
    x_ext = {{(AW-W){x_sx}}, in_x};
    y_ext = {{(XW-W){y_sx}}, in_y};
`ifdef BOOTH_MUL_ACC_EN
    do_acc = in_acc;
`else
    do_acc = 1'b0;
`endif
    acc_base = do_acc ? {{2{in_signed & out_p[2*W-1]}}, out_p} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      cnt       <= '0;
      x_sh      <= '0;
      y_sh      <= '0;
      y_prev    <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid) begin
            x_sh     <= x_ext;
            y_sh     <= y_ext;
            y_prev   <= 1'b0;
            acc      <= acc_base;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == FIN) begin
            out_p     <= acc[2*W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc    <= acc_nxt;
            x_sh   <= x_sh << 2;
            y_sh   <= y_sh >> 2;
            y_prev <= y_sh[1];
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corners plus randomized
// regression on four widths in parallel against an arithmetic model.
module tb_booth_mul_seq;

  localparam int WS [4] = '{4, 8, 16, 32};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [4];
  logic        sg   [4];
  logic        ordy [4];
  logic        ac   [4];
  logic [31:0] xs   [4];
  logic [31:0] ys   [4];
  logic        ir   [4];
  logic        ov   [4];
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] prev [4];

  always #5 clk = ~clk;

  booth_mul_seq #(.W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_x(xs[0][3:0]), .in_y(ys[0][3:0]), .in_signed(sg[0]),
`ifdef BOOTH_MUL_ACC_EN
    .in_acc(ac[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(p4));

  booth_mul_seq #(.W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_x(xs[1][7:0]), .in_y(ys[1][7:0]), .in_signed(sg[1]),
`ifdef BOOTH_MUL_ACC_EN
    .in_acc(ac[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(p8));

  booth_mul_seq #(.W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_x(xs[2][15:0]), .in_y(ys[2][15:0]), .in_signed(sg[2]),
`ifdef BOOTH_MUL_ACC_EN
    .in_acc(ac[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_p(p16));

  booth_mul_seq #(.W(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_x(xs[3][31:0]), .in_y(ys[3][31:0]), .in_signed(sg[3]),
`ifdef BOOTH_MUL_ACC_EN
    .in_acc(ac[3]),
`endif
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_p(p32));

  function automatic logic [63:0] get_p(input int k);
    case (k)
      0:       return {56'b0, p4};
      1:       return {48'b0, p8};
      2:       return {32'b0, p16};
      default: return p32;
    endcase
  endfunction

  function automatic logic [31:0] lowm(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [63:0] mask2(input int w);
    return (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
  endfunction

  // Operand value as an integer in the selected mode.
  function automatic longint ext(input int w, input logic [31:0] v, input logic s);
    logic [31:0] m;
    longint      r;
    m = v & lowm(w);
    r = longint'({32'b0, m});
    if (s && m[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  task automatic do_txn(input int k, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic a, input int stall, input bit poke,
                        output logic [63:0] got);
    int          w;
    int          n;
    logic [63:0] exp;
    w = WS[k];
`ifndef BOOTH_MUL_ACC_EN
    a = 1'b0;
`endif
    exp = ext(w, x, s) * ext(w, y, s);
    if (a) exp = exp + prev[k];
    exp = exp & mask2(w);

    total++;
    if (ir[k] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before w=%0d: got %b want 1", w, ir[k]);
    end
    xs[k] = x & lowm(w);
    ys[k] = y & lowm(w);
    sg[k] = s;
    ac[k] = a;
    iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    xs[k] = $urandom & lowm(w);
    ys[k] = $urandom & lowm(w);
    sg[k] = ~s;
    ac[k] = ~a;

    n = 0;
    while (ov[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (poke) begin
        if (n == 2) begin iv[k] = 1'b1; xs[k] = 32'h1234 & lowm(w); end
        if (n == 4) iv[k] = 1'b0;
      end
    end
    total++;
    if (n != w/2 + 2) begin
      bad++;
      $display("FAIL latency w=%0d: got %0d want %0d", w, n, w/2 + 2);
    end
    got = get_p(k);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL product w=%0d x=%h y=%h s=%b a=%b: got %h want %h",
               w, x & lowm(w), y & lowm(w), s, a, got, exp);
    end

    repeat (stall) begin
      @(negedge clk);
      total++;
      if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || get_p(k) !== exp) begin
        bad++;
        $display("FAIL hold w=%0d: got ov=%b ir=%b p=%h want ov=1 ir=0 p=%h",
                 w, ov[k], ir[k], get_p(k), exp);
      end
    end

    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    total++;
    if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || get_p(k) !== exp) begin
      bad++;
      $display("FAIL release w=%0d: got ov=%b ir=%b p=%h want ov=0 ir=1 p=%h",
               w, ov[k], ir[k], get_p(k), exp);
    end
    prev[k] = exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; sg[k] = 1'b0; ac[k] = 1'b0;
      xs[k] = '0; ys[k] = '0; prev[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || get_p(k) !== 64'd0) begin
        bad++;
        $display("FAIL reset w=%0d: got ir=%b ov=%b p=%h want 1 0 0",
                 WS[k], ir[k], ov[k], get_p(k));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed_corners();
    logic [63:0] got;
    do_txn(2, 32'h8000, 32'h8000, 1'b1, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'h4000_0000) begin
      bad++; $display("FAIL min_sq: got %h want 40000000", got);
    end
    do_txn(2, 32'hFFFF, 32'h0001, 1'b1, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'hFFFF_FFFF) begin
      bad++; $display("FAIL neg_one: got %h want ffffffff", got);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] got;
    do_txn(2, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'hFFFE_0001) begin
      bad++; $display("FAIL umax_sq: got %h want fffe0001", got);
    end
    do_txn(2, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'h1) begin
      bad++; $display("FAIL smax_sq: got %h want 00000001", got);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] got;
    do_txn(2, 32'h7A5C, 32'hC3E1, 1'b1, 1'b0, 20, 1'b0, got);
    do_txn(2, 32'h0F0F, 32'h0003, 1'b0, 1'b0, 2, 1'b1, got);
    total++;
    if (got !== 64'h2D2D) begin
      bad++; $display("FAIL busy_poke: got %h want 2d2d", got);
    end
    do_txn(2, 32'h0002, 32'h0021, 1'b0, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'h42) begin
      bad++; $display("FAIL after_poke: got %h want 42", got);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] got;
    xs[2] = 32'h1234; ys[2] = 32'h5678; sg[2] = 1'b0; ac[2] = 1'b0; iv[2] = 1'b1;
    @(negedge clk);
    iv[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1 || p16 !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: got ov=%b ir=%b p=%h want 0 1 0", ov[2], ir[2], p16);
    end
    for (int k = 0; k < 4; k++) prev[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(2, 32'd3, 32'd5, 1'b0, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'd15) begin
      bad++; $display("FAIL post_reset: got %0d want 15", got);
    end
  endtask

`ifdef BOOTH_MUL_ACC_EN
  task automatic test_accumulate();
    logic [63:0] got;
    do_txn(1, 32'd5, 32'd7, 1'b1, 1'b0, 0, 1'b0, got);
    total++;
    if (got !== 64'd35) begin bad++; $display("FAIL acc0: got %0d want 35", got); end
    do_txn(1, 32'hFD, 32'd4, 1'b1, 1'b1, 0, 1'b0, got);
    total++;
    if (got !== 64'd23) begin bad++; $display("FAIL acc1: got %0d want 23", got); end
    do_txn(1, 32'h7F, 32'h7F, 1'b1, 1'b1, 1, 1'b0, got);
    total++;
    if (got !== 64'd16152) begin bad++; $display("FAIL acc2: got %0d want 16152", got); end
  endtask
`endif

  task automatic run_random(input int k, input int count);
    logic [63:0] got;
    logic [31:0] x, y;
    int          w;
    int          stall;
    w = WS[k];
    for (int i = 0; i < count; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) x = $urandom_range(0, 1) ? 32'hFFFF_FFFF : (32'd1 << (w-1));
      if ($urandom_range(0, 7) == 0) y = $urandom_range(0, 1) ? 32'd0 : (32'd1 << (w-1));
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      do_txn(k, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), stall, 1'b0, got);
    end
  endtask

  task automatic test_random();
    fork
      run_random(0, 2500);
      run_random(1, 2500);
      run_random(2, 2500);
      run_random(3, 2500);
    join
  endtask

  initial begin
    test_reset();
    test_signed_corners();
    test_unsigned();
    test_backpressure();
    test_mid_reset();
`ifdef BOOTH_MUL_ACC_EN
    test_accumulate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
